// File: rtl/tilelink_pkg.sv
// Shared TileLink-UL definitions for the interconnect.
// Contents:
//   - A/D channel struct typedefs.
//   - Opcode constants.
//   - xbar_entry: one in-order tracking record per accepted request.
package tilelink_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_ready;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_ready;
  } tilelink_d;

  // idx == N_DEV marks the internal error target.
  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] source;
    logic [2:0] size;
    logic       is_get;
  } xbar_entry;

endpackage

// File: rtl/tl_order_fifo.sv
// In-order tracking FIFO of xbar_entry records.
// Ports:
//   - clock, reset_in (async, active-high).
//   - push + push_entry: write one record (ignored when full).
//   - pop: retire the head record (ignored when empty).
//   - head: the oldest record.
//   - full, empty: derived from the registered pointers only.
module tl_order_fifo
  import tilelink_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset_in,
  input  logic      push,
  input  xbar_entry push_entry,
  input  logic      pop,
  output xbar_entry head,
  output logic      full,
  output logic      empty
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IW;
  localparam logic [PW-1:0] WRAP_ONLY = PW'(1) << (PW - 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  xbar_entry     mem [SLOTS];

  // With a single slot there are no index bits, so slot 0 is always used.
  assign wr_idx = (DEPTH > 1) ? IW'(wr_ptr) : '0;
  assign rd_idx = (DEPTH > 1) ? IW'(rd_ptr) : '0;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == WRAP_ONLY);
  assign head  = mem[rd_idx];

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_idx] <= push_entry;
  end

endmodule

// File: rtl/tilelink_xbar.sv
// 1-host to N-device TileLink-UL interconnect with in-order responses.
// Ports:
//   - clock, reset_in: clock and async active-high reset.
//   - host_tla: host request; its a_ready field is ignored.
//   - host_tld: response to the host; d_ready flags acceptance this cycle.
//   - dev_tla[N_DEV]: broadcast payload, per-device a_valid, a_ready tied 1.
//   - dev_tld[N_DEV]: per-device responses.
//   - decode_err_count: saturating count of unmapped requests.
//   - protocol_err: sticky flag for responses from a device not at the head.
//   - busy: requests outstanding.
module tilelink_xbar
  import tilelink_pkg::*;
#(
  parameter int N_DEV = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [N_DEV-1:0][31:0] ADDR_MASK = {N_DEV{32'hF0000000}},
  parameter logic [N_DEV-1:0][31:0] ADDR_TAG =
    {32'h20000000, 32'hF0000000, 32'h80000000, 32'h00000000}
) (
  input  logic                  clock,
  input  logic                  reset_in,
  input  tilelink_a             host_tla,
  output tilelink_d             host_tld,
  output tilelink_a [N_DEV-1:0] dev_tla,
  input  tilelink_d [N_DEV-1:0] dev_tld,
  output logic [15:0]           decode_err_count,
  output logic                  protocol_err,
  output logic                  busy
);

  localparam logic [3:0] ERR_IDX = 4'(N_DEV);

  logic      accept;
  logic      pop;
  logic      fault;
  logic      full;
  logic      empty;
  logic [3:0] target;
  xbar_entry push_entry;
  xbar_entry head;

  // Scan downward so the lowest matching device index wins.
  always_comb begin
    target = ERR_IDX;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if ((host_tla.a_address & ADDR_MASK[i]) == ADDR_TAG[i]) target = 4'(i);
    end
  end

  // Reset gating keeps every output quiet while reset is asserted.
  assign accept = host_tla.a_valid && !full && !reset_in;

  assign push_entry.idx    = target;
  assign push_entry.source = host_tla.a_source;
  assign push_entry.size   = host_tla.a_size;
  assign push_entry.is_get = (host_tla.a_opcode == OP_GET);

  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      dev_tla[i]         = host_tla;
      dev_tla[i].a_valid = accept && (target == 4'(i));
      dev_tla[i].a_ready = 1'b1;
    end
  end

  // Only the head's target may answer; an error entry answers by itself
  // the first cycle it reaches the head. Any other d_valid is dropped.
  always_comb begin
    host_tld = '0;
    pop      = 1'b0;
    fault    = 1'b0;
    if (!empty && head.idx == ERR_IDX) begin
      host_tld.d_valid  = 1'b1;
      host_tld.d_error  = 1'b1;
      host_tld.d_opcode = head.is_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
      host_tld.d_source = head.source;
      host_tld.d_size   = head.size;
      pop               = 1'b1;
    end
    for (int j = 0; j < N_DEV; j++) begin
      if (dev_tld[j].d_valid) begin
        if (!empty && head.idx == 4'(j)) begin
          host_tld = dev_tld[j];
          pop      = 1'b1;
        end else begin
          fault = 1'b1;
        end
      end
    end
    host_tld.d_ready = accept;
  end

  tl_order_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clock     (clock),
    .reset_in  (reset_in),
    .push      (accept),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      decode_err_count <= '0;
      protocol_err     <= 1'b0;
    end else begin
      if (accept && target == ERR_IDX && decode_err_count != 16'hFFFF)
        decode_err_count <= decode_err_count + 16'd1;
      if (fault) protocol_err <= 1'b1;
    end
  end

  assign busy = !empty;

endmodule

// File: tb/tb_tilelink_xbar.sv
// Self-checking bench for tilelink_xbar with default parameters.
// Expected host responses are queued when a request is accepted and
// compared when the host D channel shows d_valid.
module tb_tilelink_xbar;
  import tilelink_pkg::*;

  typedef struct {
    logic [2:0]  opcode;
    logic        error;
    logic [7:0]  source;
    logic [2:0]  size;
    logic [31:0] data;
  } exp_t;

  logic            clock;
  logic            reset_in;
  tilelink_a       host_tla;
  tilelink_d       host_tld;
  tilelink_a [3:0] dev_tla;
  tilelink_d [3:0] dev_tld;
  logic [15:0]     decode_err_count;
  logic            protocol_err;
  logic            busy;
  logic [3:0]      av;

  int   tests_run;
  int   tests_failed;
  exp_t sb[$];

  tilelink_xbar dut (
    .clock           (clock),
    .reset_in        (reset_in),
    .host_tla        (host_tla),
    .host_tld        (host_tld),
    .dev_tla         (dev_tla),
    .dev_tld         (dev_tld),
    .decode_err_count(decode_err_count),
    .protocol_err    (protocol_err),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    av = '0;
    for (int i = 0; i < 4; i++) av[i] = dev_tla[i].a_valid;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clock);
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] addr,
                           input logic [7:0] src, input logic [2:0] size);
    host_tla           = '0;
    host_tla.a_valid   = 1'b1;
    host_tla.a_opcode  = op;
    host_tla.a_size    = size;
    host_tla.a_source  = src;
    host_tla.a_address = addr;
    host_tla.a_mask    = 4'hF;
  endtask

  task automatic drive_dev(input int j, input logic [2:0] op, input logic [31:0] data,
                           input logic [7:0] src, input logic [2:0] size);
    tilelink_d r;
    r          = '0;
    r.d_valid  = 1'b1;
    r.d_opcode = op;
    r.d_data   = data;
    r.d_source = src;
    r.d_size   = size;
    dev_tld    = '0;
    dev_tld[j] = r;
  endtask

  task automatic push_exp(input logic [2:0] op, input logic err, input logic [7:0] src,
                          input logic [2:0] size, input logic [31:0] data);
    exp_t e;
    e.opcode = op;
    e.error  = err;
    e.source = src;
    e.size   = size;
    e.data   = data;
    sb.push_back(e);
  endtask

  // An empty scoreboard yields X fields so any comparison against it fails.
  function automatic logic [47:0] pop_exp();
    exp_t e;
    if (sb.size() == 0) return 'x;
    e = sb.pop_front();
    return {1'b1, e.opcode, e.error, e.source, e.size, e.data};
  endfunction

  function automatic logic [47:0] got_resp();
    return {host_tld.d_valid, host_tld.d_opcode, host_tld.d_error,
            host_tld.d_source, host_tld.d_size, host_tld.d_data};
  endfunction

  task automatic test_reset();
    logic [47:0] e;
    reset_in = 1'b1;
    host_tla = '0;
    dev_tld  = '0;
    next_cycle();
    drive_req(OP_GET, 32'h0000_0000, 8'd1, 3'd2);
    mid_cycle();
    tests_run++;
    if ({busy, protocol_err, decode_err_count} !== 18'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got busy/perr/cnt %h, want 0",
               {busy, protocol_err, decode_err_count});
    end
    e = '0;
    tests_run++;
    if ({host_tld.d_ready, got_resp(), av} !== {1'b0, e, 4'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got d_ready %b resp %h a_valid %b, want all 0",
               host_tld.d_ready, got_resp(), av);
    end
    next_cycle();
    host_tla = '0;
    reset_in = 1'b0;
    next_cycle();
  endtask

  task automatic test_dev_get();
    logic [47:0] e;
    drive_req(OP_GET, 32'h8000_0010, 8'd5, 3'd2);
    mid_cycle();
    tests_run++;
    if ({host_tld.d_ready, av} !== 5'b1_0010) begin
      tests_failed++;
      $display("[TB] FAIL dev_get_accept: got d_ready %b a_valid %b, want 1 0010",
               host_tld.d_ready, av);
    end
    push_exp(OP_ACCESS_ACK_DATA, 1'b0, 8'd5, 3'd2, 32'h1234_5678);
    next_cycle();
    host_tla = '0;
    drive_dev(1, OP_ACCESS_ACK_DATA, 32'h1234_5678, 8'd5, 3'd2);
    mid_cycle();
    e = pop_exp();
    tests_run++;
    if (got_resp() !== e) begin
      tests_failed++;
      $display("[TB] FAIL dev_get_resp: got %h, want %h", got_resp(), e);
    end
    next_cycle();
    dev_tld = '0;
    mid_cycle();
    tests_run++;
    if ({busy, protocol_err} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL dev_get_idle: got busy/perr %b, want 00", {busy, protocol_err});
    end
  endtask

  task automatic test_decode_err();
    logic [47:0] e;
    next_cycle();
    drive_req(OP_GET, 32'h4000_0000, 8'd7, 3'd2);
    mid_cycle();
    tests_run++;
    if ({host_tld.d_ready, host_tld.d_valid, av} !== 6'b10_0000) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_accept: got d_ready %b d_valid %b a_valid %b, want 1 0 0000",
               host_tld.d_ready, host_tld.d_valid, av);
    end
    push_exp(OP_ACCESS_ACK_DATA, 1'b1, 8'd7, 3'd2, 32'h0);
    next_cycle();
    host_tla = '0;
    mid_cycle();
    e = pop_exp();
    tests_run++;
    if (got_resp() !== e) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_resp: got %h, want %h", got_resp(), e);
    end
    tests_run++;
    if (decode_err_count !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_count: got %0d, want 1", decode_err_count);
    end
    next_cycle();
    mid_cycle();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL unmapped_idle: got busy %b, want 0", busy);
    end
  endtask

  task automatic test_full();
    logic [47:0] e;
    next_cycle();
    drive_req(OP_GET, 32'h0000_0000, 8'd1, 3'd2);
    mid_cycle();
    tests_run++;
    if ({host_tld.d_ready, av} !== 5'b1_0001) begin
      tests_failed++;
      $display("[TB] FAIL full_first: got d_ready %b a_valid %b, want 1 0001", host_tld.d_ready, av);
    end
    push_exp(OP_ACCESS_ACK_DATA, 1'b0, 8'd1, 3'd2, 32'h1111_0000);
    next_cycle();
    drive_req(OP_GET, 32'hF000_0000, 8'd2, 3'd2);
    mid_cycle();
    tests_run++;
    if ({host_tld.d_ready, av} !== 5'b1_0100) begin
      tests_failed++;
      $display("[TB] FAIL full_second: got d_ready %b a_valid %b, want 1 0100", host_tld.d_ready, av);
    end
    push_exp(OP_ACCESS_ACK_DATA, 1'b0, 8'd2, 3'd2, 32'h2222_0000);
    next_cycle();
    drive_req(OP_GET, 32'h8000_0000, 8'd3, 3'd2);
    mid_cycle();
    tests_run++;
    if ({host_tld.d_ready, av, busy} !== 6'b0_0000_1) begin
      tests_failed++;
      $display("[TB] FAIL full_block: got d_ready %b a_valid %b busy %b, want 0 0000 1",
               host_tld.d_ready, av, busy);
    end
    next_cycle();
    drive_dev(0, OP_ACCESS_ACK_DATA, 32'h1111_0000, 8'd1, 3'd2);
    mid_cycle();
    tests_run++;
    if ({host_tld.d_ready, av} !== 5'b0_0000) begin
      tests_failed++;
      $display("[TB] FAIL full_pop_no_space: got d_ready %b a_valid %b, want 0 0000", host_tld.d_ready, av);
    end
    e = pop_exp();
    tests_run++;
    if (got_resp() !== e) begin
      tests_failed++;
      $display("[TB] FAIL full_resp0: got %h, want %h", got_resp(), e);
    end
    next_cycle();
    drive_dev(2, OP_ACCESS_ACK_DATA, 32'h2222_0000, 8'd2, 3'd2);
    mid_cycle();
    e = pop_exp();
    tests_run++;
    if (got_resp() !== e) begin
      tests_failed++;
      $display("[TB] FAIL full_resp2: got %h, want %h", got_resp(), e);
    end
    tests_run++;
    if ({host_tld.d_ready, av} !== 5'b1_0010) begin
      tests_failed++;
      $display("[TB] FAIL full_retry: got d_ready %b a_valid %b, want 1 0010", host_tld.d_ready, av);
    end
    push_exp(OP_ACCESS_ACK_DATA, 1'b0, 8'd3, 3'd2, 32'h3333_0000);
    next_cycle();
    host_tla = '0;
    drive_dev(1, OP_ACCESS_ACK_DATA, 32'h3333_0000, 8'd3, 3'd2);
    mid_cycle();
    e = pop_exp();
    tests_run++;
    if (got_resp() !== e) begin
      tests_failed++;
      $display("[TB] FAIL full_resp1: got %h, want %h", got_resp(), e);
    end
    next_cycle();
    dev_tld = '0;
    mid_cycle();
    tests_run++;
    if ({busy, protocol_err} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL full_idle: got busy/perr %b, want 00", {busy, protocol_err});
    end
  endtask

  task automatic test_out_of_order();
    logic [47:0] e;
    next_cycle();
    drive_req(OP_GET, 32'h0000_0100, 8'd4, 3'd2);
    push_exp(OP_ACCESS_ACK_DATA, 1'b0, 8'd4, 3'd2, 32'hCAFE_F00D);
    next_cycle();
    drive_req(OP_PUT_FULL, 32'h8000_0000, 8'd6, 3'd2);
    push_exp(OP_ACCESS_ACK, 1'b0, 8'd6, 3'd2, 32'h0);
    next_cycle();
    host_tla = '0;
    drive_dev(1, OP_ACCESS_ACK, 32'h0, 8'd6, 3'd2);
    mid_cycle();
    tests_run++;
    if (host_tld.d_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ooo_dropped: got d_valid %b, want 0", host_tld.d_valid);
    end
    next_cycle();
    drive_dev(0, OP_ACCESS_ACK_DATA, 32'hCAFE_F00D, 8'd4, 3'd2);
    mid_cycle();
    tests_run++;
    if (protocol_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ooo_protocol_err: got %b, want 1", protocol_err);
    end
    e = pop_exp();
    tests_run++;
    if (got_resp() !== e) begin
      tests_failed++;
      $display("[TB] FAIL ooo_resp0: got %h, want %h", got_resp(), e);
    end
    next_cycle();
    drive_dev(1, OP_ACCESS_ACK, 32'h0, 8'd6, 3'd2);
    mid_cycle();
    e = pop_exp();
    tests_run++;
    if (got_resp() !== e) begin
      tests_failed++;
      $display("[TB] FAIL ooo_resp1: got %h, want %h", got_resp(), e);
    end
    next_cycle();
    dev_tld = '0;
  endtask

  task automatic test_put_err();
    logic [47:0] e;
    drive_req(OP_PUT_FULL, 32'hF000_0000, 8'd8, 3'd2);
    push_exp(OP_ACCESS_ACK, 1'b0, 8'd8, 3'd2, 32'h0);
    next_cycle();
    drive_req(OP_PUT_FULL, 32'h4000_0004, 8'd9, 3'd1);
    mid_cycle();
    tests_run++;
    if ({host_tld.d_ready, av} !== 5'b1_0000) begin
      tests_failed++;
      $display("[TB] FAIL put_err_accept: got d_ready %b a_valid %b, want 1 0000", host_tld.d_ready, av);
    end
    push_exp(OP_ACCESS_ACK, 1'b1, 8'd9, 3'd1, 32'h0);
    next_cycle();
    host_tla = '0;
    drive_dev(2, OP_ACCESS_ACK, 32'h0, 8'd8, 3'd2);
    mid_cycle();
    e = pop_exp();
    tests_run++;
    if (got_resp() !== e) begin
      tests_failed++;
      $display("[TB] FAIL put_dev2_resp: got %h, want %h", got_resp(), e);
    end
    next_cycle();
    dev_tld = '0;
    mid_cycle();
    e = pop_exp();
    tests_run++;
    if (got_resp() !== e) begin
      tests_failed++;
      $display("[TB] FAIL put_err_resp: got %h, want %h", got_resp(), e);
    end
    tests_run++;
    if (decode_err_count !== 16'd2) begin
      tests_failed++;
      $display("[TB] FAIL put_err_count: got %0d, want 2", decode_err_count);
    end
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    drive_req(OP_GET, 32'h0000_0000, 8'd1, 3'd2);
    next_cycle();
    drive_req(OP_GET, 32'h0000_0004, 8'd2, 3'd2);
    next_cycle();
    host_tla = '0;
    mid_cycle();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midflight_busy: got %b, want 1", busy);
    end
    reset_in = 1'b1;
    sb.delete();
    #1;
    tests_run++;
    if ({busy, protocol_err, decode_err_count} !== 18'd0) begin
      tests_failed++;
      $display("[TB] FAIL midflight_async_reset: got busy/perr/cnt %h, want 0",
               {busy, protocol_err, decode_err_count});
    end
    next_cycle();
    reset_in = 1'b0;
    next_cycle();
    drive_dev(0, OP_ACCESS_ACK_DATA, 32'hDEAD_BEEF, 8'd1, 3'd2);
    mid_cycle();
    tests_run++;
    if ({host_tld.d_valid, protocol_err} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL stale_dropped: got d_valid/perr %b, want 00", {host_tld.d_valid, protocol_err});
    end
    next_cycle();
    dev_tld = '0;
    mid_cycle();
    tests_run++;
    if ({protocol_err, busy, decode_err_count} !== {1'b1, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("[TB] FAIL stale_flags: got perr/busy/cnt %h, want %h",
               {protocol_err, busy, decode_err_count}, {1'b1, 1'b0, 16'd0});
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_dev_get();
    test_decode_err();
    test_full();
    test_out_of_order();
    test_put_err();
    test_reset_midflight();
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drained: got %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tilelink_xbar.md
Name: tilelink_xbar

Overview:
- Parametrised 1-host to N-device TileLink-UL interconnect; replaces the hard-wired two-device response mux in the top level.
- Decodes each host A-channel request by per-device mask/tag and forwards it to exactly one device.
- Tracks outstanding requests in order and returns D responses to the host in issue order.
- Generates error responses for unmapped addresses and reports decode/protocol faults.

Parameters:
- N_DEV, 4: number of device ports, 1..8.
- MAX_OUTSTANDING, 2: depth of the in-order tracking FIFO; power of two, 1..8.
- ADDR_MASK, {N_DEV{32'hF0000000}}: packed N_DEV x 32 array, per-device address mask.
- ADDR_TAG, {32'hF0000000, 32'h80000000, 32'h00000000}...: packed N_DEV x 32 array, per-device tag. Device i matches when (a_address & ADDR_MASK[i]) == ADDR_TAG[i].

Ports:
- clock  in  1  single clock.
- reset_in  in  1  asynchronous, active-high reset.
- host_tla  in  tilelink_a  request from the core. a_ready is ignored.
- host_tld  out  tilelink_d  response to the core. d_ready = request accepted this cycle.
- dev_tla  out  tilelink_a[N_DEV]  per-device request. Payload is broadcast; a_valid is gated per device; a_ready is driven 1.
- dev_tld  in  tilelink_d[N_DEV]  per-device response.
- decode_err_count  out  16  saturating count of unmapped requests.
- protocol_err  out  1  sticky flag: a device returned d_valid when it was not at the FIFO head.
- busy  out  1  FIFO non-empty.

Behaviour:
- Reset (async assert): FIFO empty, all outputs low, host_tld fields 0, decode_err_count=0, protocol_err=0, every dev_tla a_valid=0.
- Decode:
  - Match uses the lowest matching index (priority encoder).
  - No match selects the internal error target, index N_DEV.
- Acceptance:
  - A request is accepted when host_tla.a_valid=1 and the FIFO is not full.
  - On acceptance, host_tld.d_ready=1 combinationally, and the matched dev_tla[i].a_valid=1 in the same cycle.
  - On acceptance, the FIFO pushes {target idx, a_source, a_size, is_get = (a_opcode==Get 3'd4)}.
  - When full, d_ready=0, no a_valid is forwarded, and the core must hold its request.
  - A pop on the same cycle does not free space for a push; full is evaluated on registered state.
- Response routing:
  - Head target h < N_DEV: host_tld = dev_tld[h] when dev_tld[h].d_valid=1; the FIFO pops the same cycle.
  - Otherwise host_tld.d_valid=0 and all other fields are 0.
- Error target at head:
  - Emitted in the first cycle the entry is at head. Because the FIFO is registered, this is at minimum 1 cycle after acceptance.
  - Response fields: d_valid=1, d_error=1, d_opcode = AccessAckData(1) if is_get else AccessAck(0), d_data=0, d_source/d_size from the entry, d_param=0, d_sink=0.
  - The entry pops that cycle.
  - decode_err_count increments at acceptance and saturates at 16'hFFFF.
- Latency:
  - Device responses: 0 added cycles; any device latency >=1 is supported.
  - Error responses: exactly 1 cycle when the FIFO was empty at acceptance.
- Faults:
  - Any dev_tld[j].d_valid=1 with j != head target, or with the FIFO empty, is dropped and sets protocol_err.
  - protocol_err clears only on reset.
  - This includes stale responses arriving after a mid-transaction reset.
- Ordering: strictly in order. A later device's early response is a protocol error, not buffered.
- Pointer arithmetic:
  - Read/write pointers are log2(MAX_OUTSTANDING)+1 bits.
  - full = MSBs differ and lower bits are equal; empty = pointers equal. Pointers wrap naturally.
- With MAX_OUTSTANDING=1 and one-cycle devices, the block is functionally equivalent to the current top-level mux plus error handling.

Decomposition:
- Shared tilelink package, extended with:
  - tilelink_a / tilelink_d typedefs (already present).
  - Opcode constants: PutFull=0, PutPartial=1, Get=4, AccessAck=0, AccessAckData=1.
  - New typedef xbar_entry {idx[3:0], source, size[2:0], is_get}.
- One sub-module: tl_order_fifo.
  - Synchronous FIFO of xbar_entry, parametrised by depth.
  - Async reset; ports push/pop/head/full/empty.

Test Plan:
- Get 0x80000010 to dev1, dev1 answers next cycle with d_data=0x12345678 -> host_tld.d_valid=1, d_data=0x12345678, d_error=0; busy low afterwards.
- Get 0x40000000 (unmapped), FIFO empty -> 1 cycle later host_tld: d_valid=1, d_error=1, d_opcode=1, d_data=0; decode_err_count=1.
- MAX_OUTSTANDING=2: back-to-back Gets to dev0 then dev2, third request in the next cycle with no responses -> third request sees d_ready=0 and no a_valid to any device.
- Issue dev0 then dev1; dev1 responds first -> protocol_err=1 and host sees nothing; dev0 then responds -> forwarded to host.
- Put 0xF0000000 (dev2) plus unmapped Put queued behind it -> dev2 AccessAck forwarded, next cycle error AccessAck (d_opcode=0, d_error=1).
- Assert reset_in with 2 outstanding requests, release, then dev0 responds -> dropped, protocol_err=1, busy=0, decode_err_count=0.
